bist_signature_analyzer: RTL

//  Response-side BIST: compacts 16-bit responses from the ring/johnson/LFSR pattern path into a MISR signature.

---
 rtl/bist_signature_analyzer.sv | 104 ++++++++++
 1 files changed

// File: rtl/bist_signature_analyzer.sv
// bist_signature_analyzer: MISR response compactor with golden compare; BIST_SIG_LOAD_EN adds runtime golden loading
module bist_signature_analyzer #(
  parameter int          PATTERN_COUNT = 16,
  parameter logic [15:0] SEED          = 16'h0000,
  parameter logic [15:0] POLY          = 16'h100B,
  parameter logic [15:0] GOLDEN_RING   = 16'h0000,
  parameter logic [15:0] GOLDEN_JOHN   = 16'h0000,
  parameter logic [15:0] GOLDEN_LFSR   = 16'h0000,
  localparam int         CNT_W         = $clog2(PATTERN_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             resp_valid,
  input  logic [15:0]      resp_data,
`ifdef BIST_SIG_LOAD_EN
  input  logic             sig_load,
  input  logic [1:0]       sig_load_sel,
  input  logic [15:0]      sig_load_data,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      signature,
  output logic [CNT_W-1:0] pattern_cnt
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAP  = 2'd1;
  localparam logic [1:0] S_CMP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PATTERN_COUNT - 1);
  logic [1:0]       r_state;
  logic [1:0]       r_mode;
  logic [15:0]      r_sig;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pass;
  logic             w_go;
  logic             w_beat;
  logic             w_fb;
  logic [15:0]      w_misr;
  logic [15:0]      w_golden;
  always_comb begin
    w_go   = start && mode != 2'b00 && (r_state == S_IDLE || r_state == S_DONE);
    w_beat = resp_valid && r_state == S_CAP;
    w_fb   = ^(r_sig & POLY);
    w_misr = {r_sig[14:0], w_fb} ^ resp_data;
  end
`ifdef BIST_SIG_LOAD_EN
  logic [15:0] r_gold_ring;
  logic [15:0] r_gold_john;
  logic [15:0] r_gold_lfsr;
  // compare reads the pre-write value, so a load in the COMPARE cycle is not seen
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gold_ring <= GOLDEN_RING;
      r_gold_john <= GOLDEN_JOHN;
      r_gold_lfsr <= GOLDEN_LFSR;
    end else if (sig_load) begin
      if (sig_load_sel == 2'b01) r_gold_ring <= sig_load_data;
      if (sig_load_sel == 2'b10) r_gold_john <= sig_load_data;
      if (sig_load_sel == 2'b11) r_gold_lfsr <= sig_load_data;
    end
  end
  always_comb begin
    w_golden = r_mode == 2'b01 ? r_gold_ring :
               r_mode == 2'b10 ? r_gold_john :
               r_mode == 2'b11 ? r_gold_lfsr : 16'h0000;
  end
`else
  always_comb begin
    w_golden = r_mode == 2'b01 ? GOLDEN_RING :
               r_mode == 2'b10 ? GOLDEN_JOHN :
               r_mode == 2'b11 ? GOLDEN_LFSR : 16'h0000;
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mode  <= 2'b00;
      r_sig   <= 16'h0000;
      r_cnt   <= '0;
      r_pass  <= 1'b0;
    end else if (w_go) begin
      r_state <= S_CAP;
      r_mode  <= mode;
      r_sig   <= SEED;
      r_cnt   <= '0;
      r_pass  <= 1'b0;
    end else if (w_beat) begin
      r_sig <= w_misr;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST) r_state <= S_CMP;
    end else if (r_state == S_CMP) begin
      r_pass  <= r_sig == w_golden;
      r_state <= S_DONE;
    end
  end
  assign busy        = r_state == S_CAP || r_state == S_CMP;
  assign done        = r_state == S_DONE;
  assign pass        = r_pass;
  assign signature   = r_sig;
  assign pattern_cnt = r_cnt;
endmodule
